// File: rtl/branch_history_table.sv
// Direct-mapped 2-bit saturating counter branch direction predictor.
// Predicts at fetch, trains at execute, and flags mispredictions one cycle later.
module branch_history_table #(
    parameter int ENTRIES = 64,
    localparam int IDX_BITS = $clog2(ENTRIES)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_valid_i,
    input  logic [31:0] if_pc_i,
    output logic        pred_taken_o,
    input  logic        ex_valid_i,
    input  logic [31:0] ex_pc_i,
    input  logic [2:0]  ex_sel_i,
    input  logic        ex_take_branch_i,
    input  logic        ex_pred_taken_i,
    output logic        mispredict_o,
    output logic        redirect_taken_o,
    output logic [31:0] branch_count_o,
    output logic [31:0] mispredict_count_o
);

    logic [1:0]          bht_r [ENTRIES];
    logic [IDX_BITS-1:0] if_idx_s;
    logic [IDX_BITS-1:0] ex_idx_s;
    logic                is_branch_s;
    logic                resolve_s;
    logic                miss_s;
    logic [1:0]          ctr_next_s;
    logic                mispredict_r;
    logic                redirect_taken_r;
    logic [31:0]         branch_count_r;
    logic [31:0]         mispredict_count_r;
    logic                unused_pc_s;

    // Saturating counter step: moves toward the resolved direction, holds at the ends.
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return nxt;
    endfunction

    assign if_idx_s    = if_pc_i[IDX_BITS+1:2];
    assign ex_idx_s    = ex_pc_i[IDX_BITS+1:2];
    assign unused_pc_s = ^{if_pc_i[31:IDX_BITS+2], if_pc_i[1:0],
                           ex_pc_i[31:IDX_BITS+2], ex_pc_i[1:0]};

    // Decode the comparator select: only the six conditional branch codes resolve.
    always_comb begin
        is_branch_s = 1'b0;
        case (ex_sel_i)
            3'h1, 3'h2, 3'h3, 3'h4, 3'h5, 3'h6: is_branch_s = 1'b1;
            default:                            is_branch_s = 1'b0;
        endcase
    end

    assign resolve_s  = ex_valid_i & is_branch_s;
    assign miss_s     = resolve_s & (ex_take_branch_i ^ ex_pred_taken_i);
    assign ctr_next_s = sat_update(bht_r[ex_idx_s], ex_take_branch_i);

    // Fetch reads the registered table directly, so a same-cycle update is not bypassed.
    assign pred_taken_o = if_valid_i & bht_r[if_idx_s][1];

    // Counter table: reset to weak not-taken, trained on each resolve.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht_r[i] <= 2'b01;
            end
        end else if (resolve_s) begin
            bht_r[ex_idx_s] <= ctr_next_s;
        end else begin
            bht_r[ex_idx_s] <= bht_r[ex_idx_s];
        end
    end

    // Mispredict pulse and wrap-around event counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mispredict_r       <= 1'b0;
            redirect_taken_r   <= 1'b0;
            branch_count_r     <= 32'd0;
            mispredict_count_r <= 32'd0;
        end else begin
            mispredict_r     <= miss_s;
            redirect_taken_r <= miss_s & ex_take_branch_i;
            if (resolve_s) begin
                branch_count_r <= branch_count_r + 32'd1;
            end else begin
                branch_count_r <= branch_count_r;
            end
            if (miss_s) begin
                mispredict_count_r <= mispredict_count_r + 32'd1;
            end else begin
                mispredict_count_r <= mispredict_count_r;
            end
        end
    end

    assign mispredict_o       = mispredict_r;
    assign redirect_taken_o   = redirect_taken_r;
    assign branch_count_o     = branch_count_r;
    assign mispredict_count_o = mispredict_count_r;

endmodule

// File: doc/branch_history_table.md
# branch_history_table

Dynamic branch direction predictor for the 32-bit RISC-V core. It predicts branch direction at fetch from a direct-mapped table of 2-bit saturating counters. It is trained at execute by the branch comparator's `take_branch` result and flags mispredictions one cycle later so the front end can redirect. It also keeps wrap-around branch and mispredict event counters for performance monitoring.

## Interface
- `ENTRIES`, 64, number of counters; power of two, 4..1024.
- `IDX_BITS`, $clog2(ENTRIES), table index width; derived, do not override.

Ports:
- `clk_i`  in  1  single clock; all state updates on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `if_valid_i`  in  1  fetch PC valid.
- `if_pc_i`  in  32  fetch PC.
- `pred_taken_o`  out  1  predicted direction for `if_pc_i`.
- `ex_valid_i`  in  1  execute-stage instruction valid, not stalled or flushed.
- `ex_pc_i`  in  32  PC of execute-stage instruction.
- `ex_sel_i`  in  3  comparator select; 3'h0 = not a branch, 3'h1..3'h6 = beq/bne/blt/bge/bltu/bgeu; 3'h7 treated as not a branch.
- `ex_take_branch_i`  in  1  resolved direction from comparator.
- `ex_pred_taken_i`  in  1  prediction carried down the pipeline with this instruction.
- `mispredict_o`  out  1  registered; resolved direction differed from prediction.
- `redirect_taken_o`  out  1  registered; correct direction for the mispredicted branch.
- `branch_count_o`  out  32  resolved branches since reset.
- `mispredict_count_o`  out  32  mispredictions since reset.

## Operation
- Index: `pc[IDX_BITS+1:2]` for both fetch and execute PCs. No tags, so aliasing is accepted.
- Counter encoding:
  - 2'b00 strong not-taken
  - 2'b01 weak not-taken
  - 2'b10 weak taken
  - 2'b11 strong taken
- Prediction = counter MSB.
- `pred_taken_o = if_valid_i & table[if_idx][1]`. Combinational read of the registered table; 0 when `if_valid_i` is low.
- Resolve event: `ex_valid_i && ex_sel_i inside {1..6}`. On a resolve event, at the clock edge:
  - Counter update:
    - taken and counter != 2'b11: increment.
    - not taken and counter != 2'b00: decrement.
    - At saturation, the counter holds.
  - `branch_count_o` += 1.
  - If `ex_take_branch_i != ex_pred_taken_i`: `mispredict_count_o` += 1, and the next-cycle `mispredict_o` = 1 with `redirect_taken_o = ex_take_branch_i`.
- Otherwise, `mispredict_o` = 0 and `redirect_taken_o` = 0 next cycle.
- `ex_take_branch_i` is ignored when `ex_sel_i` is 0 or 7. Non-branch or invalid cycles change nothing but clear `mispredict_o`.
- Event counters are 32-bit and wrap modulo 2^32 (0xFFFFFFFF + 1 = 0). They do not saturate.
- `ex_pred_taken_i` is trusted as supplied. The block does not re-read the table at execute.

## Timing
- Reset, with `rst_i` high at an edge:
  - Every table entry is set to 2'b01.
  - `mispredict_o`, `redirect_taken_o`, `branch_count_o` and `mispredict_count_o` are 0.
  - `pred_taken_o` reads 0 in the cycle after reset.
- `rst_i` dominates any simultaneous resolve event. A branch resolving in a reset cycle is discarded, and no mispredict is reported.
- Prediction latency: 0 cycles (same-cycle combinational).
- Training latency: an update from a resolve at edge N is visible to fetch reads from cycle N+1.
- Same-index collision (fetch and execute index the same entry in one cycle): fetch sees the pre-update value. There is no bypass.
- `mispredict_o` and `redirect_taken_o` are single-cycle pulses asserted the cycle after the resolve. Back-to-back mispredicting resolves give back-to-back pulses.
- Counter outputs are registered and reflect all events up to and including the previous edge.

## Test plan
- Reset, then sweep `if_pc_i` over all ENTRIES indices with `if_valid_i`=1 -> `pred_taken_o`=0 everywhere; both counters 0; `mispredict_o`=0.
- Saturation: four resolves at PC 0x100 with taken=1 and pred=0 -> counter goes 01→10→11→11; `pred_taken_o` at PC 0x100 is 1 from the cycle after the first update; `mispredict_count_o`=4; `branch_count_o`=4. Then one not-taken resolve -> counter 10, prediction still 1.
- Mispredict pulse: resolve beq with take=1, pred=1, then bne with take=0, pred=1 on consecutive cycles -> `mispredict_o` reads 0 then 1 with `redirect_taken_o`=0, then 0.
- Filtering: `ex_sel_i`=0 and `ex_sel_i`=7 with take=1, plus `ex_valid_i`=0 with `ex_sel_i`=3 -> no table change, counters unchanged, no pulse.
- Collision and aliasing: fetch and resolve PC 0x40 in the same cycle -> old prediction that cycle, new value next cycle. With ENTRIES=64, training PC 0x40 also changes the prediction at PC 0x140.
- Reset mid-operation and wrap:
  - Assert `rst_i` in the same cycle as a mispredicting resolve -> no pulse next cycle; all state reset.
  - Force `branch_count_o` to 0xFFFFFFFF, then one resolve -> 0x00000000.
